// File: rtl/key_pad_emu.sv
// key_pad_emu: responder side of a 4x3 key-pad matrix.
// Accepts one key press per valid/ready command and answers the scanner's
// active-low row drive with the active-low column of the held key.
// Optional contact chatter at press/release: define KEY_PAD_EMU_BOUNCE_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for a command, key_ready high
// PBOUNCE | press chatter, contact alternates (bounce build only)
// PRESS   | key closed, counting complete scanner sweeps
// RBOUNCE | release chatter, contact alternates (bounce build only)
// GAP     | key open, lockout before the next command

module key_pad_emu #(
  parameter int HOLD_SCANS    = 4,
  parameter int GAP_CYCLES    = 16,
  parameter int BOUNCE_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] key_pad_row,
  output logic [2:0] key_pad_column,
  output logic       key_pad_flag,
  output logic       key_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PBOUNCE = 3'd1,
    PRESS   = 3'd2,
    RBOUNCE = 3'd3,
    GAP     = 3'd4
  } state_t;

  localparam logic [7:0]  HOLD_MAX = 8'(HOLD_SCANS);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
`ifdef KEY_PAD_EMU_BOUNCE_EN
  localparam logic [7:0]  BNC_LAST = 8'(BOUNCE_CYCLES - 1);
`endif

  state_t      state, state_nx;
  logic [3:0]  row_sel, row_sel_nx;   // one-hot, bit set = key's row
  logic [2:0]  col_sel, col_sel_nx;   // one-hot, bit set = key's column
  logic        contact, contact_nx;
  logic [7:0]  hold_cnt, hold_nx, hold_inc;
  logic [15:0] gap_cnt, gap_nx;
  logic        err_nx;
  logic        accept;
  logic [3:0]  dec_row;
  logic [2:0]  dec_col;
  logic        dec_legal;
`ifdef KEY_PAD_EMU_BOUNCE_EN
  logic [7:0]  bounce_cnt, bounce_nx, bounce_inc;
`endif

  assign key_ready = (state == IDLE);
  assign accept    = key_valid && key_ready;
  assign busy      = (state != IDLE);
  assign hold_inc  = hold_cnt + 8'd1;
`ifdef KEY_PAD_EMU_BOUNCE_EN
  assign bounce_inc = bounce_cnt + 8'd1;
`endif

  // Key code to row/column position; codes 12..15 are not on the pad.
  always_comb begin
    dec_row   = 4'b0000;
    dec_col   = 3'b000;
    dec_legal = 1'b1;
    case (key_code)
      4'd1:    begin dec_row = 4'b1000; dec_col = 3'b100; end
      4'd2:    begin dec_row = 4'b1000; dec_col = 3'b010; end
      4'd3:    begin dec_row = 4'b1000; dec_col = 3'b001; end
      4'd4:    begin dec_row = 4'b0100; dec_col = 3'b100; end
      4'd5:    begin dec_row = 4'b0100; dec_col = 3'b010; end
      4'd6:    begin dec_row = 4'b0100; dec_col = 3'b001; end
      4'd7:    begin dec_row = 4'b0010; dec_col = 3'b100; end
      4'd8:    begin dec_row = 4'b0010; dec_col = 3'b010; end
      4'd9:    begin dec_row = 4'b0010; dec_col = 3'b001; end
      4'd10:   begin dec_row = 4'b0001; dec_col = 3'b100; end
      4'd0:    begin dec_row = 4'b0001; dec_col = 3'b010; end
      4'd11:   begin dec_row = 4'b0001; dec_col = 3'b001; end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state, contact and counter updates.
  always_comb begin
    state_nx   = state;
    row_sel_nx = row_sel;
    col_sel_nx = col_sel;
    contact_nx = contact;
    hold_nx    = hold_cnt;
    gap_nx     = gap_cnt;
    err_nx     = 1'b0;
`ifdef KEY_PAD_EMU_BOUNCE_EN
    bounce_nx  = bounce_cnt;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (dec_legal) begin
            row_sel_nx = dec_row;
            col_sel_nx = dec_col;
            contact_nx = 1'b1;
            hold_nx    = 8'd0;
            gap_nx     = 16'd0;
`ifdef KEY_PAD_EMU_BOUNCE_EN
            state_nx   = PBOUNCE;
            bounce_nx  = 8'd0;
`else
            state_nx   = PRESS;
`endif
          end else begin
            err_nx = 1'b1;
          end
        end
      end
`ifdef KEY_PAD_EMU_BOUNCE_EN
      PBOUNCE: begin
        if (bounce_cnt == BNC_LAST) begin
          state_nx   = PRESS;
          bounce_nx  = 8'd0;
          contact_nx = 1'b1;
        end else begin
          bounce_nx  = bounce_inc;
          contact_nx = ~bounce_inc[0];
        end
      end
      RBOUNCE: begin
        if (bounce_cnt == BNC_LAST) begin
          state_nx   = GAP;
          bounce_nx  = 8'd0;
          contact_nx = 1'b0;
        end else begin
          bounce_nx  = bounce_inc;
          contact_nx = bounce_inc[0];
        end
      end
`endif
      PRESS: begin
        // Only the last row of a sweep advances the hold count.
        if (key_pad_row == 4'b1110) begin
          if (hold_inc == HOLD_MAX) begin
            hold_nx    = 8'd0;
            contact_nx = 1'b0;
`ifdef KEY_PAD_EMU_BOUNCE_EN
            state_nx   = RBOUNCE;
            bounce_nx  = 8'd0;
`else
            state_nx   = GAP;
`endif
          end else begin
            hold_nx = hold_inc;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nx = IDLE;
          gap_nx   = 16'd0;
        end else begin
          gap_nx = gap_cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      row_sel  <= 4'b0000;
      col_sel  <= 3'b000;
      contact  <= 1'b0;
      hold_cnt <= 8'd0;
      gap_cnt  <= 16'd0;
      key_err  <= 1'b0;
`ifdef KEY_PAD_EMU_BOUNCE_EN
      bounce_cnt <= 8'd0;
`endif
    end else begin
      state    <= state_nx;
      row_sel  <= row_sel_nx;
      col_sel  <= col_sel_nx;
      contact  <= contact_nx;
      hold_cnt <= hold_nx;
      gap_cnt  <= gap_nx;
      key_err  <= err_nx;
`ifdef KEY_PAD_EMU_BOUNCE_EN
      bounce_cnt <= bounce_nx;
`endif
    end
  end

  // Column answers the current row drive combinationally so the scanner
  // sees it on the same edge it drives the row.
  always_comb begin
    key_pad_column = ~(col_sel & {3{contact & (|(row_sel & ~key_pad_row))}});
    key_pad_flag   = !((state == PRESS) || (state == PBOUNCE) || (state == RBOUNCE));
  end

endmodule

// File: tb/tb_key_pad_emu.sv
// Scoreboard bench for key_pad_emu: stimulus process predicts each cycle's
// outputs from a timeline model of the key pad and queues them; a monitor
// compares them on the falling edge. Honours KEY_PAD_EMU_BOUNCE_EN.

module tb_key_pad_emu;

  localparam int HOLD = 4;
  localparam int GAP  = 16;
  localparam int BNCP = 4;
`ifdef KEY_PAD_EMU_BOUNCE_EN
  localparam int BNC = BNCP;
`else
  localparam int BNC = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_code = 4'd0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic [3:0] key_pad_row = 4'hF;
  logic [2:0] key_pad_column;
  logic       key_pad_flag;
  logic       key_err;
  logic       busy;

  key_pad_emu #(.HOLD_SCANS(HOLD), .GAP_CYCLES(GAP), .BOUNCE_CYCLES(BNCP)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .key_pad_row(key_pad_row),
    .key_pad_column(key_pad_column), .key_pad_flag(key_pad_flag),
    .key_err(key_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] col;
    logic       flag;
    logic       ready;
    logic       busy;
    logic       err;
    bit         in_rst;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model: remaining cycles/sweeps of each phase of the current key press
  int pb_left = 0, sw_left = 0, rb_left = 0, gap_left = 0;
  logic [3:0] held = 4'd0;
  bit err_pend = 1'b0;
  bit accepted = 1'b0;
  int sweep_ph = 0;

  task automatic chk(input string name, input int c, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, exp);
    end
  endtask

  // Monitor: compare whatever the stimulus predicted for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("column", e.cyc, {1'b0, key_pad_column}, {1'b0, e.col});
        chk("flag",   e.cyc, {3'b0, key_pad_flag}, {3'b0, e.flag});
        chk("busy",   e.cyc, {3'b0, busy}, {3'b0, e.busy});
        chk("key_err", e.cyc, {3'b0, key_err}, {3'b0, e.err});
        if (!e.in_rst) chk("key_ready", e.cyc, {3'b0, key_ready}, {3'b0, e.ready});
      end
    end
  end

  function automatic logic [2:0] key_col(input logic [3:0] code, input logic [3:0] row);
    int r, c;
    if (code == 4'd0)       begin r = 3; c = 1; end
    else if (code == 4'd10) begin r = 3; c = 0; end
    else if (code == 4'd11) begin r = 3; c = 2; end
    else begin r = (int'(code) - 1) / 3; c = (int'(code) - 1) % 3; end
    if (row[3-r] == 1'b0) return 3'b111 ^ (3'b100 >> c);
    return 3'b111;
  endfunction

  function automatic logic [3:0] sweep_row(input int ph);
    case (ph % 4)
      0: return 4'b0111;
      1: return 4'b1011;
      2: return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic step(input bit v, input logic [3:0] code, input logic [3:0] row);
    exp_t e;
    bit pressing, closed, idle;
    @(posedge clk);
    #1;
    rst = 1'b0;
    key_valid = v;
    key_code = code;
    key_pad_row = row;
    cyc++;
    pressing = 1'b0;
    closed = 1'b0;
    if (pb_left > 0) begin pressing = 1'b1; closed = ((BNC - pb_left) % 2) == 0; end
    else if (sw_left > 0) begin pressing = 1'b1; closed = 1'b1; end
    else if (rb_left > 0) begin pressing = 1'b1; closed = ((BNC - rb_left) % 2) == 1; end
    idle = !pressing && (gap_left == 0);
    e.col = closed ? key_col(held, row) : 3'b111;
    e.flag = !pressing;
    e.ready = idle;
    e.busy = !idle;
    e.err = err_pend;
    e.in_rst = 1'b0;
    e.cyc = cyc;
    q.push_back(e);
    err_pend = 1'b0;
    accepted = 1'b0;
    if (pb_left > 0) pb_left--;
    else if (sw_left > 0) begin
      if (row == 4'b1110) begin
        sw_left--;
        if (sw_left == 0) begin rb_left = BNC; gap_left = GAP; end
      end
    end
    else if (rb_left > 0) rb_left--;
    else if (gap_left > 0) gap_left--;
    else if (v) begin
      if (code <= 4'd11) begin
        held = code; pb_left = BNC; sw_left = HOLD; accepted = 1'b1;
      end else begin
        err_pend = 1'b1;
      end
    end
  endtask

  task automatic pulse_reset();
    exp_t e;
    @(posedge clk);
    #1;
    rst = 1'b1;
    key_valid = 1'b0;
    cyc++;
    pb_left = 0; sw_left = 0; rb_left = 0; gap_left = 0; err_pend = 1'b0;
    e.col = 3'b111; e.flag = 1'b1; e.ready = 1'b1; e.busy = 1'b0; e.err = 1'b0;
    e.in_rst = 1'b1; e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic run_sweep(input int n, input bit v, input logic [3:0] code);
    for (int i = 0; i < n; i++) begin
      step(v, code, sweep_row(sweep_ph));
      sweep_ph++;
    end
  endtask

  initial begin
    logic [3:0] dir_codes[4];
    bit got;
    dir_codes[0] = 4'd5; dir_codes[1] = 4'd11; dir_codes[2] = 4'd0; dir_codes[3] = 4'd10;
    repeat (2) @(posedge clk);
    pulse_reset();

    // Directed legal keys with a regular scanner sweep.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, dir_codes[k], sweep_row(sweep_ph)); sweep_ph++;
      run_sweep(1 + BNC + 4 * HOLD + BNC + GAP + 3, 1'b0, 4'd0);
    end

    // Illegal code.
    step(1'b1, 4'd13, sweep_row(sweep_ph)); sweep_ph++;
    run_sweep(3, 1'b0, 4'd0);

    // Valid held through a press: the new code waits for IDLE.
    step(1'b1, 4'd3, sweep_row(sweep_ph)); sweep_ph++;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      run_sweep(1, 1'b1, 4'd1);
      got = accepted;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL held_valid_accept: model never reached IDLE within 200 cycles");
    end

    // Parked on row 0111 mid-press, then reset.
    for (int i = 0; i < 6 + BNC; i++) step(1'b0, 4'd0, 4'b0111);
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 4'b0111);

`ifdef KEY_PAD_EMU_BOUNCE_EN
    // Chatter on a parked row: 011,111,011,111 then steady 011.
    step(1'b1, 4'd1, 4'b0111);
    for (int i = 0; i < 10; i++) step(1'b0, 4'd0, 4'b0111);
    pulse_reset();
`endif

    // Random commands and row drive.
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] row;
      if ($urandom_range(0, 399) == 0) pulse_reset();
      else begin
        if ($urandom_range(0, 9) < 8) begin row = sweep_row(sweep_ph); sweep_ph++; end
        else row = 4'($urandom_range(0, 15));
        step($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), row);
      end
    end

    step(1'b0, 4'd0, 4'hF);
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
